mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX next to the ALU and takes the same operand buses (rs -> i_data_a, rt -> i_data_b).
- Its result mux output joins the ALU result on the way to EX/MEM.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, serves MFHI/MFLO/MTHI/MTLO, and raises a stall to the hazard unit while HI/LO are not yet valid.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_iter_core.sv | 55 +++++
 rtl/mdu_hilo.sv | 177 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared EX-stage decode constants: ALU/MDU funct codes, MDU FSM encoding and
// small decode helpers.
package mdu_pkg;

  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;

  localparam logic [5:0] MDU_MFHI  = 6'b010000;
  localparam logic [5:0] MDU_MTHI  = 6'b010001;
  localparam logic [5:0] MDU_MFLO  = 6'b010010;
  localparam logic [5:0] MDU_MTLO  = 6'b010011;
  localparam logic [5:0] MDU_MULT  = 6'b011000;
  localparam logic [5:0] MDU_MULTU = 6'b011001;
  localparam logic [5:0] MDU_DIV   = 6'b011010;
  localparam logic [5:0] MDU_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_muldiv_op(input logic [5:0] funct);
    return (funct == MDU_MULT) || (funct == MDU_MULTU) ||
           (funct == MDU_DIV)  || (funct == MDU_DIVU);
  endfunction

  function automatic logic is_mdu_op(input logic [5:0] funct);
    return is_muldiv_op(funct) ||
           (funct == MDU_MFHI) || (funct == MDU_MTHI) ||
           (funct == MDU_MFLO) || (funct == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle magnitude datapath: radix-2 shift-add multiply or
// restoring divide sharing a single HI:LO shift register pair.
module mdu_iter_core #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_is_div,
  input  logic [BITS_SIZE-1:0] i_mag_a,
  input  logic [BITS_SIZE-1:0] i_mag_b,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  logic [BITS_SIZE-1:0] r_hi;
  logic [BITS_SIZE-1:0] r_lo;
  logic [BITS_SIZE-1:0] r_b;

  logic [BITS_SIZE:0]   w_b_ext;
  logic [BITS_SIZE:0]   w_sum;
  logic [BITS_SIZE:0]   w_shl;
  logic [BITS_SIZE-1:0] w_diff;
  logic                 w_ge;

  // Multiply: r_lo holds the multiplier and collects product low bits.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  always_comb begin
    w_b_ext = {1'b0, r_b};
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? w_b_ext : '0);
    w_shl   = {r_hi, r_lo[BITS_SIZE-1]};
    w_ge    = (w_shl >= w_b_ext);
    w_diff  = w_shl[BITS_SIZE-1:0] - r_b;
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_hi <= '0;
      r_lo <= i_mag_a;
      r_b  <= i_mag_b;
    end else if (i_step) begin
      if (i_is_div) begin
        r_hi <= w_ge ? w_diff : w_shl[BITS_SIZE-1:0];
        r_lo <= {r_lo[BITS_SIZE-2:0], w_ge};
      end else begin
        r_hi <= w_sum[BITS_SIZE:1];
        r_lo <= {w_sum[0], r_lo[BITS_SIZE-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/DIV unit with architectural HI/LO, MFHI/MFLO read mux and
// EX-stage stall generation.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int BITS_OP   = 6,
  parameter int BITS_CNT  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [BITS_OP-1:0]   i_op,
  input  logic [BITS_SIZE-1:0] i_data_a,
  input  logic [BITS_SIZE-1:0] i_data_b,
  input  logic                 i_flush,
  output logic [BITS_SIZE-1:0] o_result,
  output logic                 o_busy,
  output logic                 o_stall,
  output logic                 o_done
);

  localparam logic [BITS_CNT-1:0] LAST_CNT = BITS_CNT'(BITS_SIZE - 1);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;

  logic [BITS_CNT-1:0]  r_cnt;
  logic [BITS_SIZE-1:0] r_hi;
  logic [BITS_SIZE-1:0] r_lo;
  logic [BITS_SIZE-1:0] r_a;
  logic                 r_done;
  logic                 r_is_div;
  logic                 r_signed;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic                 r_b_zero;

  logic                   w_is_muldiv;
  logic                   w_op_signed;
  logic                   w_op_div;
  logic                   w_start;
  logic                   w_step;
  logic                   w_commit;
  logic                   w_mt_ok;
  logic [BITS_SIZE-1:0]   w_mag_a;
  logic [BITS_SIZE-1:0]   w_mag_b;
  logic [BITS_SIZE-1:0]   w_core_hi;
  logic [BITS_SIZE-1:0]   w_core_lo;
  logic [2*BITS_SIZE-1:0] w_prod;
  logic [BITS_SIZE-1:0]   w_quo;
  logic [BITS_SIZE-1:0]   w_rem;
  logic [BITS_SIZE-1:0]   w_new_hi;
  logic [BITS_SIZE-1:0]   w_new_lo;

  assign w_is_muldiv = is_muldiv_op(i_op);
  assign w_op_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
  assign w_op_div    = (i_op == MDU_DIV)  || (i_op == MDU_DIVU);
  assign w_mag_a     = (w_op_signed && i_data_a[BITS_SIZE-1]) ? -i_data_a : i_data_a;
  assign w_mag_b     = (w_op_signed && i_data_b[BITS_SIZE-1]) ? -i_data_b : i_data_b;
  assign w_mt_ok     = i_valid && !i_flush && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid && !i_flush && w_is_muldiv) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == LAST_CNT) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_commit    = !i_flush;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_commit;
      if (w_start) begin
        r_cnt    <= '0;
        r_is_div <= w_op_div;
        r_signed <= w_op_signed;
        r_neg_a  <= w_op_signed && i_data_a[BITS_SIZE-1];
        r_neg_b  <= w_op_signed && i_data_b[BITS_SIZE-1];
        r_b_zero <= (i_data_b == '0);
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Raw dividend is kept only for the divide-by-zero HI result.
  always_ff @(posedge i_clk) begin
    if (w_start) r_a <= i_data_a;
  end

  mdu_iter_core #(
    .BITS_SIZE (BITS_SIZE)
  ) u_core (
    .i_clk    (i_clk),
    .i_load   (w_start),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_mag_a  (w_mag_a),
    .i_mag_b  (w_mag_b),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Sign fixup: product negated on sign mismatch; quotient likewise, remainder
  // follows the dividend. Divide-by-zero bypasses the fixup entirely.
  always_comb begin
    w_prod = {w_core_hi, w_core_lo};
    if (r_signed && (r_neg_a ^ r_neg_b)) w_prod = -w_prod;
    w_quo = (r_signed && (r_neg_a ^ r_neg_b)) ? -w_core_lo : w_core_lo;
    w_rem = (r_signed && r_neg_a) ? -w_core_hi : w_core_hi;
    if (!r_is_div) begin
      w_new_hi = w_prod[2*BITS_SIZE-1:BITS_SIZE];
      w_new_lo = w_prod[BITS_SIZE-1:0];
    end else if (r_b_zero) begin
      w_new_hi = r_a;
      w_new_lo = '1;
    end else begin
      w_new_hi = w_rem;
      w_new_lo = w_quo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_new_hi;
      r_lo <= w_new_lo;
    end else if (w_mt_ok) begin
      if (i_op == MDU_MTHI) r_hi <= i_data_a;
      if (i_op == MDU_MTLO) r_lo <= i_data_a;
    end
  end

  always_comb begin
    o_result = '0;
    if (i_valid && (i_op == MDU_MFHI)) o_result = r_hi;
    else if (i_valid && (i_op == MDU_MFLO)) o_result = r_lo;
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;
  assign o_stall = i_valid && o_busy && is_mdu_op(i_op);

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed plan cases plus random MULT/DIV
// traffic checked against a plain-arithmetic reference model.
module tb_mdu_hilo;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] result;
  logic        busy;
  logic        stall;
  logic        done;

  int          errs;
  int          checks;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_op     (op),
    .i_data_a (a),
    .i_data_b (b),
    .i_flush  (flush),
    .o_result (result),
    .o_busy   (busy),
    .o_stall  (stall),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (f)
      OP_MULTU: p = {32'd0, x} * {32'd0, y};
      OP_MULT:  p = 64'(sx * sy);
      OP_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      OP_DIV: begin
        if (y == 0) begin
          p = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag);
    valid = 1'b1;
    op    = OP_MFHI;
    #1;
    chk({tag, " HI"}, result, m_hi);
    op = OP_MFLO;
    #1;
    chk({tag, " LO"}, result, m_lo);
    valid = 1'b0;
    op    = '0;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    int n;
    logic [63:0] p;
    @(negedge clk);
    valid = 1'b1;
    op    = f;
    a     = x;
    b     = y;
    @(negedge clk);
    valid = 1'b0;
    op    = '0;
    a     = $urandom;
    b     = $urandom;
    n     = 1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd34);
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    p    = ref_mdu(f, x, y);
    m_hi = p[63:32];
    m_lo = p[31:0];
    read_hilo(tag);
  endtask

  initial begin
    int n;
    int dcount;
    logic [31:0] ta;
    logic [31:0] tb;
    logic [63:0] p;
    logic [5:0] ops [4];
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    errs = 0; checks = 0;
    m_hi = '0; m_lo = '0;
    rst_n = 1'b0; valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;

    repeat (2) @(negedge clk);
    valid = 1'b1;
    op    = OP_MULT;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset result nonMF", result, 32'd0);
    valid = 1'b0;
    read_hilo("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult -1*2");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
    run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0002, "divu 7/2");
    run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0000, "divu by0");
    run_op(OP_DIV,   32'h0000_0007, 32'h0000_0000, "div by0");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, "div neg by0");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div ovf");

    // MFLO stalled behind a running MULT
    @(negedge clk);
    ta = $urandom; tb = $urandom;
    valid = 1'b1; op = OP_MULT; a = ta; b = tb;
    @(negedge clk);
    op = OP_MFLO; a = $urandom; b = $urandom;
    #1;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      chk("stall while busy", 32'(stall), 32'd1);
      @(negedge clk);
      #1;
      n++;
    end
    p = ref_mdu(OP_MULT, ta, tb);
    m_hi = p[63:32];
    m_lo = p[31:0];
    chk("stall latency", 32'(n), 32'd34);
    chk("stall@done", 32'(stall), 32'd0);
    chk("MFLO@done", result, m_lo);
    valid = 1'b0; op = '0;
    read_hilo("after stall");

    // MTHI / MTLO then a flushed MULT
    @(negedge clk);
    valid = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    valid = 1'b0; op = '0; a = '0;
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    read_hilo("mthi/mtlo");

    @(negedge clk);
    valid = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    valid = 1'b0; op = '0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("busy after flush", 32'(busy), 32'd0);
    dcount = 0;
    repeat (45) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("done after flush", 32'(dcount), 32'd0);
    read_hilo("flushed mult");

    // flush coincident with start: nothing starts
    @(negedge clk);
    valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; op = '0; flush = 1'b0;
    #1;
    chk("flush+start busy", 32'(busy), 32'd0);
    read_hilo("flush+start");

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    valid = 1'b1; op = OP_DIV; a = $urandom; b = $urandom_range(1, 1000);
    @(negedge clk);
    valid = 1'b0; op = '0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("busy in reset", 32'(busy), 32'd0);
    m_hi = '0;
    m_lo = '0;
    read_hilo("mid-div reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MULT, 32'd6, 32'd7, "mult 6*7");

    for (int i = 0; i < 10; i++) begin
      ta = $urandom;
      if (i % 3 == 1) tb = $urandom_range(1, 15);
      else if (i == 5) tb = 32'd0;
      else tb = $urandom;
      run_op(ops[$urandom_range(0, 3)], ta, tb, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
